// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the LED mode controller: mode encoding,
// mode-advance order and divider sizing.
package led_ctrl_pkg;

  typedef enum logic [2:0] {
    OFF  = 3'd0,
    ON   = 3'd1,
    SLOW = 3'd2,
    FAST = 3'd3,
    RUN  = 3'd4
  } mode_e;

  // Codes 5-7 are unreachable; treating them as RUN's successor returns to OFF.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      OFF:     return ON;
      ON:      return SLOW;
      SLOW:    return FAST;
      FAST:    return RUN;
      default: return OFF;
    endcase
  endfunction

  function automatic int half_div(input int clk_hz, input int hz);
    return clk_hz / (2 * hz);
  endfunction

endpackage

// File: rtl/led_mode_ctrl_tick_gen.sv
// Free-running divider: counts 0..DIV-1 and flags the terminal count.
// A synchronous clear restarts the count from 0.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick
);

  localparam int             CW   = $clog2(DIV);
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: state flops use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              cnt <= '0;
    else if (clr)           cnt <= '0;
    else if (cnt == LAST)   cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_mode_ctrl.sv
// Mode FSM driving an LED bank: OFF, ON, SLOW/FAST blink and a RUN marquee.
// Mode and LED pattern update on the same edge that samples a press pulse.
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int N_LED   = 4,
  parameter int CLK_HZ  = 50_000_000,
  parameter int SLOW_HZ = 1,
  parameter int FAST_HZ = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mode_pulse,
  input  logic             clr_pulse,
  output logic [N_LED-1:0] led,
  output logic [2:0]       mode
);

  localparam int SLOW_DIV = half_div(CLK_HZ, SLOW_HZ);
  localparam int FAST_DIV = half_div(CLK_HZ, FAST_HZ);

  if (SLOW_DIV < 2) begin : g_bad_slow
    $error("led_mode_ctrl: SLOW_DIV must be >= 2");
  end
  if (FAST_DIV < 2) begin : g_bad_fast
    $error("led_mode_ctrl: FAST_DIV must be >= 2");
  end
  if (N_LED < 2) begin : g_bad_nled
    $error("led_mode_ctrl: N_LED must be >= 2");
  end

  mode_e mode_q;
  mode_e mode_d;
  logic  phase;
  logic  mode_change;
  logic  slow_tick;
  logic  fast_tick;

  // Any press, including clr while already OFF, restarts all LED timing.
  assign mode_change = clr_pulse | mode_pulse;
  assign mode_d      = clr_pulse ? OFF : next_mode(mode_q);

  tick_gen #(.DIV(SLOW_DIV)) u_slow_tick (
    .clk  (clk),
    .rstn (rstn),
    .clr  (mode_change),
    .tick (slow_tick)
  );

  tick_gen #(.DIV(FAST_DIV)) u_fast_tick (
    .clk  (clk),
    .rstn (rstn),
    .clr  (mode_change),
    .tick (fast_tick)
  );

  // In RUN the led register itself holds the one-hot marquee position.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q <= OFF;
      phase  <= 1'b0;
      led    <= '0;
    end else if (mode_change) begin
      mode_q <= mode_d;
      phase  <= 1'b1;
      case (mode_d)
        ON, SLOW, FAST: led <= '1;
        RUN:            led <= N_LED'(1);
        default:        led <= '0;
      endcase
    end else begin
      case (mode_q)
        SLOW: if (slow_tick) begin
          phase <= ~phase;
          led   <= {N_LED{~phase}};
        end
        FAST: if (fast_tick) begin
          phase <= ~phase;
          led   <= {N_LED{~phase}};
        end
        RUN: if (fast_tick) begin
          led <= {led[N_LED-2:0], led[N_LED-1]};
        end
        default: ;
      endcase
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with CLK_HZ=16 (SLOW_DIV=8, FAST_DIV=2), N_LED=4.
module tb_led_mode_ctrl;

  logic       clk;
  logic       rstn;
  logic       mode_pulse;
  logic       clr_pulse;
  logic [3:0] led;
  logic [2:0] mode;

  int n_tests = 0;
  int n_fail  = 0;

  led_mode_ctrl #(
    .N_LED   (4),
    .CLK_HZ  (16),
    .SLOW_HZ (1),
    .FAST_HZ (4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .mode_pulse (mode_pulse),
    .clr_pulse  (clr_pulse),
    .led        (led),
    .mode       (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press();
    mode_pulse = 1'b1;
    step();
    mode_pulse = 1'b0;
  endtask

  task automatic press_n(input int n);
    for (int i = 0; i < n; i++) press();
  endtask

  initial begin
    rstn       = 1'b0;
    mode_pulse = 1'b0;
    clr_pulse  = 1'b0;

    // 1. Reset, then 100 idle cycles.
    idle(3);
    check("rst_led_low", led, 4'b0000);
    check("rst_mode_low", mode, 3'd0);
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      check("idle_led", led, 4'b0000);
      check("idle_mode", mode, 3'd0);
      step();
    end

    // 2. Mode sequence; pulse has no effect before its edge.
    mode_pulse = 1'b1;
    #2;
    check("pre_edge_mode", mode, 3'd0);
    step();
    mode_pulse = 1'b0;
    check("on_mode", mode, 3'd1);
    check("on_led", led, 4'b1111);
    idle(19);
    check("on_hold_led", led, 4'b1111);

    // 3. SLOW blink: 8 lit, 8 dark, 8 lit.
    press();
    check("slow_mode", mode, 3'd2);
    for (int i = 0; i < 24; i++) begin
      check($sformatf("slow_%0d", i), led, ((i / 8) % 2 == 0) ? 4'b1111 : 4'b0000);
      step();
    end

    // FAST blink: 2 lit, 2 dark.
    press();
    check("fast_mode", mode, 3'd3);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("fast_%0d", i), led, ((i / 2) % 2 == 0) ? 4'b1111 : 4'b0000);
      step();
    end

    // 4. RUN marquee, 2 cycles per step, wrapping.
    press();
    check("run_mode", mode, 3'd4);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("run_%0d", i), led, 4'b0001 << ((i / 2) % 4));
      step();
    end

    press();
    check("wrap_mode", mode, 3'd0);
    check("wrap_led", led, 4'b0000);
    idle(19);

    // Pulse on a fast-tick cycle in FAST: RUN still starts fresh at 0001 x2.
    press_n(3);
    check("fast2_mode", mode, 3'd3);
    idle(1);
    check("fast2_tick_cycle", led, 4'b1111);
    press();
    check("restart_mode", mode, 3'd4);
    check("restart_0", led, 4'b0001);
    step();
    check("restart_1", led, 4'b0001);
    step();
    check("restart_2", led, 4'b0010);

    // 5. clr and mode together in RUN: clr wins.
    clr_pulse  = 1'b1;
    mode_pulse = 1'b1;
    step();
    clr_pulse  = 1'b0;
    mode_pulse = 1'b0;
    check("coll_mode", mode, 3'd0);
    check("coll_led", led, 4'b0000);

    // Held mode_pulse counts every cycle.
    mode_pulse = 1'b1;
    idle(3);
    mode_pulse = 1'b0;
    check("held_mode", mode, 3'd3);
    check("held_led", led, 4'b1111);

    // clr mid SLOW blink goes straight to OFF.
    press_n(4);
    check("slow3_mode", mode, 3'd2);
    idle(10);
    check("slow3_dark", led, 4'b0000);
    clr_pulse = 1'b1;
    step();
    clr_pulse = 1'b0;
    check("clr_slow_mode", mode, 3'd0);
    check("clr_slow_led", led, 4'b0000);

    // 6. Async reset mid-RUN, between edges.
    press_n(4);
    idle(3);
    check("run2_led", led, 4'b0010);
    #2;
    rstn = 1'b0;
    #1;
    check("async_led", led, 4'b0000);
    check("async_mode", mode, 3'd0);
    idle(2);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("post_rst_led", led, 4'b0000);
      step();
    end
    check("post_rst_mode", mode, 3'd0);
    press();
    check("post_rst_on_mode", mode, 3'd1);
    check("post_rst_on_led", led, 4'b1111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
